// File: rtl/reg_wb_buffer_if.sv
// Bus bundle for reg_wb_buffer: request side, register-file write port and the two forwarding lookups.
interface reg_wb_buffer_if #(
    parameter int W     = 8,
    parameter int D     = 3,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_imm;
    logic [D-1:0]  req_addr;
    logic [W-1:0]  req_data;
    logic          req_ready;
    logic          drain_hold;
    logic          write_en;
    logic          write_imm;
    logic [D-1:0]  waddr;
    logic [W-1:0]  data_in;
    logic [D-1:0]  raddrA;
    logic [D-1:0]  raddrB;
    logic          fwd_hitA;
    logic          fwd_hitB;
    logic [W-1:0]  fwd_dataA;
    logic [W-1:0]  fwd_dataB;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output req_valid, req_imm, req_addr, req_data, drain_hold, raddrA, raddrB,
        input  req_ready, write_en, write_imm, waddr, data_in,
               fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB, count, empty
    );

    modport slave (
        input  req_valid, req_imm, req_addr, req_data, drain_hold, raddrA, raddrB,
        output req_ready, write_en, write_imm, waddr, data_in,
               fwd_hitA, fwd_hitB, fwd_dataA, fwd_dataB, count, empty
    );
endinterface

// File: rtl/reg_wb_buffer.sv
// In-order write-back FIFO feeding the register-file write port, with
// youngest-entry forwarding for two read ports.
module reg_wb_buffer #(
    parameter int W     = 8,
    parameter int D     = 3,
    parameter int DEPTH = 4
) (
    input logic            CLK,
    input logic            Init_n,
    reg_wb_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [D-1:0]  RIM  = {D{1'b1}};
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic         imm;
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          empty, push, pop;
    entry_t        hd;

    assign empty = (count == '0);
    assign push  = bus.req_valid && bus.req_ready;
    assign pop   = bus.write_en;
    assign hd    = mem[head];

    // Ready looks only at registered occupancy, so a full buffer refuses even while popping.
    assign bus.req_ready = (count < FULL);
    assign bus.write_en  = !empty && !bus.drain_hold;
    assign bus.write_imm = empty ? 1'b0 : hd.imm;
    assign bus.waddr     = empty ? '0   : hd.addr;
    assign bus.data_in   = empty ? '0   : hd.data;
    assign bus.count     = count;
    assign bus.empty     = empty;

    always_ff @(posedge CLK or negedge Init_n) begin
        if (!Init_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payloads need no reset; occupancy alone decides what is visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail].imm  <= bus.req_imm;
            mem[tail].addr <= bus.req_imm ? RIM : bus.req_addr;
            mem[tail].data <= bus.req_data;
        end
    end

    // Slot g is the g-th oldest entry; valid while g < count.
    logic [DEPTH-1:0]        hit_a, hit_b;
    logic [DEPTH-1:0][W-1:0] slot_data;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic [PW-1:0] idx;
        logic          vld;
        assign idx          = head + PW'(g);
        assign vld          = (CW'(g) < count);
        assign hit_a[g]     = vld && (mem[idx].addr == bus.raddrA);
        assign hit_b[g]     = vld && (mem[idx].addr == bus.raddrB);
        assign slot_data[g] = mem[idx].data;
    end

    logic         fa, fb;
    logic [W-1:0] da, db;

    // Scan oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        fa = 1'b0;
        fb = 1'b0;
        da = '0;
        db = '0;
        for (int g = 0; g < DEPTH; g++) begin
            if (hit_a[g]) begin
                fa = 1'b1;
                da = slot_data[g];
            end
            if (hit_b[g]) begin
                fb = 1'b1;
                db = slot_data[g];
            end
        end
    end

    assign bus.fwd_hitA  = fa;
    assign bus.fwd_hitB  = fb;
    assign bus.fwd_dataA = da;
    assign bus.fwd_dataB = db;
endmodule

// File: tb/tb_reg_wb_buffer.sv
// Directed bench for reg_wb_buffer: hand-computed expectations for push, drain,
// hold, forwarding, wrap, full refusal and mid-cycle reset.
module tb_reg_wb_buffer;
    logic clk = 1'b0;
    logic init_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    reg_wb_buffer_if #(.W(8), .D(3), .DEPTH(4)) bus ();

    reg_wb_buffer #(.W(8), .D(3), .DEPTH(4)) dut (
        .CLK    (clk),
        .Init_n (init_n),
        .bus    (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_imm   = 1'b0;
        bus.req_addr  = a;
        bus.req_data  = d;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_imm    = 1'b0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.drain_hold = 1'b0;
        bus.raddrA     = '0;
        bus.raddrB     = '0;

        // reset state
        #12;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_wen", 32'(bus.write_en), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_waddr", 32'(bus.waddr), 32'd0);
        chk("rst_data", 32'(bus.data_in), 32'd0);
        chk("rst_hitA", 32'(bus.fwd_hitA), 32'd0);
        chk("rst_fdatB", 32'(bus.fwd_dataB), 32'd0);
        @(negedge clk);
        init_n = 1'b1;
        tick();

        // single push, one-cycle latency, forwarding from next cycle
        bus.req_valid = 1'b1;
        bus.req_addr  = 3'd3;
        bus.req_data  = 8'h5A;
        bus.raddrA    = 3'd3;
        #2;
        chk("t1_ready", 32'(bus.req_ready), 32'd1);
        chk("t1_nohit_same", 32'(bus.fwd_hitA), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        #2;
        chk("t1_wen", 32'(bus.write_en), 32'd1);
        chk("t1_waddr", 32'(bus.waddr), 32'd3);
        chk("t1_data", 32'(bus.data_in), 32'h5A);
        chk("t1_imm", 32'(bus.write_imm), 32'd0);
        chk("t1_hitA", 32'(bus.fwd_hitA), 32'd1);
        chk("t1_fdatA", 32'(bus.fwd_dataA), 32'h5A);
        tick();
        #2;
        chk("t1_empty", 32'(bus.empty), 32'd1);
        chk("t1_wen0", 32'(bus.write_en), 32'd0);
        chk("t1_hitA0", 32'(bus.fwd_hitA), 32'd0);

        // RIM request
        bus.req_valid = 1'b1;
        bus.req_imm   = 1'b1;
        bus.req_addr  = 3'd2;
        bus.req_data  = 8'h11;
        tick();
        bus.req_valid = 1'b0;
        bus.req_imm   = 1'b0;
        bus.raddrB    = 3'd7;
        #2;
        chk("t2_imm", 32'(bus.write_imm), 32'd1);
        chk("t2_waddr", 32'(bus.waddr), 32'd7);
        chk("t2_data", 32'(bus.data_in), 32'h11);
        chk("t2_hitB", 32'(bus.fwd_hitB), 32'd1);
        chk("t2_fdatB", 32'(bus.fwd_dataB), 32'h11);
        bus.raddrB = 3'd2;
        #1;
        chk("t2_hitB_raw", 32'(bus.fwd_hitB), 32'd0);
        chk("t2_fdatB_raw", 32'(bus.fwd_dataB), 32'd0);
        tick();

        // hold, fill, refuse 5th, youngest forwarding, ordered drain
        bus.drain_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(3'd1, 8'(i));
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h05;
        #2;
        chk("t3_count", 32'(bus.count), 32'd4);
        chk("t3_ready", 32'(bus.req_ready), 32'd0);
        chk("t3_wen_held", 32'(bus.write_en), 32'd0);
        tick();
        bus.req_valid = 1'b0;
        bus.raddrA    = 3'd1;
        #2;
        chk("t3_count_5th", 32'(bus.count), 32'd4);
        chk("t3_hitA", 32'(bus.fwd_hitA), 32'd1);
        chk("t3_youngest", 32'(bus.fwd_dataA), 32'h04);
        bus.drain_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("t3_drain_wen", 32'(bus.write_en), 32'd1);
            chk("t3_drain_data", 32'(bus.data_in), 32'(i));
            tick();
        end
        #2;
        chk("t3_empty", 32'(bus.empty), 32'd1);

        // continuous push+pop at count=1 across pointer wrap
        push(3'd6, 8'h20);
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 3'd6;
            bus.req_data  = 8'(8'h21 + c);
            #2;
            chk("t4_wen", 32'(bus.write_en), 32'd1);
            chk("t4_data", 32'(bus.data_in), 32'(8'h20 + c));
            chk("t4_count", 32'(bus.count), 32'd1);
            tick();
        end
        bus.req_valid = 1'b0;
        #2;
        chk("t4_last", 32'(bus.data_in), 32'h2A);
        tick();
        #2;
        chk("t4_empty", 32'(bus.empty), 32'd1);

        // full buffer: pop and request in same cycle -> refused, then accepted
        bus.drain_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(3'd5, 8'(8'h30 + i));
        bus.drain_hold = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 3'd5;
        bus.req_data   = 8'h35;
        #2;
        chk("t6_ready_full", 32'(bus.req_ready), 32'd0);
        chk("t6_pop_data", 32'(bus.data_in), 32'h31);
        tick();
        bus.drain_hold = 1'b1;
        #2;
        chk("t6_count3", 32'(bus.count), 32'd3);
        chk("t6_ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid  = 1'b0;
        bus.drain_hold = 1'b0;
        #2;
        chk("t6_count4", 32'(bus.count), 32'd4);
        for (int i = 2; i <= 5; i++) begin
            chk("t6_order", 32'(bus.data_in), 32'(8'h30 + i));
            tick();
            #2;
        end
        chk("t6_empty", 32'(bus.empty), 32'd1);

        // asynchronous reset mid-cycle with 3 entries pending
        bus.drain_hold = 1'b1;
        for (int i = 1; i <= 3; i++) push(3'd4, 8'(8'h40 + i));
        #3;
        chk("t5_count_pre", 32'(bus.count), 32'd3);
        init_n = 1'b0;
        #1;
        chk("t5_count", 32'(bus.count), 32'd0);
        chk("t5_wen", 32'(bus.write_en), 32'd0);
        bus.drain_hold = 1'b0;
        bus.raddrA     = 3'd4;
        #1;
        chk("t5_wen_nohold", 32'(bus.write_en), 32'd0);
        chk("t5_hitA", 32'(bus.fwd_hitA), 32'd0);
        @(negedge clk);
        init_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            #2;
            chk("t5_no_write", 32'(bus.write_en), 32'd0);
        end
        chk("t5_empty", 32'(bus.empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
